// File: rtl/mem_access_pkg.sv
// Shared widths, op codes, FSM states and bus payload for the memory-access stage.
package mem_access_pkg;

   localparam int unsigned REG_BUS       = 32;
   localparam int unsigned REG_ADDR_BUS  = 5;
   localparam int unsigned STALL_BUS     = 6;
   localparam int unsigned MEM_OP_BUS    = 4;
   localparam int unsigned STALL_MEM_BIT = 4;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   localparam logic [MEM_OP_BUS-1:0] OP_NONE = 4'd0;
   localparam logic [MEM_OP_BUS-1:0] OP_LB   = 4'd1;
   localparam logic [MEM_OP_BUS-1:0] OP_LBU  = 4'd2;
   localparam logic [MEM_OP_BUS-1:0] OP_LH   = 4'd3;
   localparam logic [MEM_OP_BUS-1:0] OP_LHU  = 4'd4;
   localparam logic [MEM_OP_BUS-1:0] OP_LW   = 4'd5;
   localparam logic [MEM_OP_BUS-1:0] OP_SB   = 4'd6;
   localparam logic [MEM_OP_BUS-1:0] OP_SH   = 4'd7;
   localparam logic [MEM_OP_BUS-1:0] OP_SW   = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Registered data-bus command held for the whole access.
   typedef struct packed {
      logic                 we;
      logic [REG_BUS-1:0]   addr;
      logic [3:0]           sel;
      logic [REG_BUS-1:0]   wdata;
   } dbus_cmd_t;

   function automatic logic is_mem_op(input logic [MEM_OP_BUS-1:0] op);
      return (op >= OP_LB) && (op <= OP_SW);
   endfunction

   function automatic logic is_store(input logic [MEM_OP_BUS-1:0] op);
      return (op >= OP_SB) && (op <= OP_SW);
   endfunction

   // Halfwords need addr[0] clear, words need addr[1:0] clear.
   function automatic logic is_misaligned(input logic [MEM_OP_BUS-1:0] op,
                                          input logic [1:0] addr_lo);
      case (op)
         OP_LH, OP_LHU, OP_SH: return addr_lo[0];
         OP_LW, OP_SW:         return addr_lo != 2'b00;
         default:              return 1'b0;
      endcase
   endfunction

   // Little-endian byte-lane enables.
   function automatic logic [3:0] lane_sel(input logic [MEM_OP_BUS-1:0] op,
                                           input logic [1:0] addr_lo);
      case (op)
         OP_LB, OP_LBU, OP_SB: return 4'b0001 << addr_lo;
         OP_LH, OP_LHU, OP_SH: return addr_lo[1] ? 4'b1100 : 4'b0011;
         OP_LW, OP_SW:         return 4'b1111;
         default:              return 4'b0000;
      endcase
   endfunction

   // Store data replicated across every lane the access could hit.
   function automatic logic [REG_BUS-1:0] store_data(input logic [MEM_OP_BUS-1:0] op,
                                                     input logic [REG_BUS-1:0] d);
      case (op)
         OP_SB:   return {4{d[7:0]}};
         OP_SH:   return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Extracts the addressed byte/halfword/word from bus read data and extends it.
module mem_load_align
   import mem_access_pkg::*;
(
   input  logic [MEM_OP_BUS-1:0] op,
   input  logic [1:0]            addr_lo,
   input  logic [REG_BUS-1:0]    rdata,
   output logic [REG_BUS-1:0]    result
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Select the addressed byte and halfword lanes.
   always_comb begin
      byte_lane = 8'h00;
      case (addr_lo)
         2'd0:    byte_lane = rdata[7:0];
         2'd1:    byte_lane = rdata[15:8];
         2'd2:    byte_lane = rdata[23:16];
         default: byte_lane = rdata[31:24];
      endcase
      half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   // Sign- or zero-extend according to the load type.
   always_comb begin
      result = '0;
      case (op)
         OP_LB:   result = {{24{byte_lane[7]}}, byte_lane};
         OP_LBU:  result = {24'h000000, byte_lane};
         OP_LH:   result = {{16{half_lane[15]}}, half_lane};
         OP_LHU:  result = {16'h0000, half_lane};
         OP_LW:   result = rdata;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: ALU pass-through plus single-outstanding load/store bus.
module mem_access
   import mem_access_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [REG_ADDR_BUS-1:0] ex_waddr_reg_i,
   input  logic                    ex_we_reg_i,
   input  logic [REG_BUS-1:0]      ex_wdata_i,
   input  logic [MEM_OP_BUS-1:0]   ex_mem_op_i,
   input  logic [REG_BUS-1:0]      ex_mem_addr_i,
   input  logic [REG_BUS-1:0]      ex_store_data_i,
   input  logic [STALL_BUS-1:0]    stall,
   output logic [REG_ADDR_BUS-1:0] mem_waddr_reg_o,
   output logic                    mem_we_reg_o,
   output logic [REG_BUS-1:0]      mem_wdata_o,
   output logic                    stallreq_mem_o,
   output logic                    addr_err_o,
   output logic                    dbus_req_o,
   output logic                    dbus_we_o,
   output logic [31:0]             dbus_addr_o,
   output logic [3:0]              dbus_sel_o,
   output logic [31:0]             dbus_wdata_o,
   input  logic [31:0]             dbus_rdata_i,
   input  logic                    dbus_ack_i
);

   state_t             state, state_next;
   dbus_cmd_t          cmd_q;
   logic               req_q;
   logic [REG_BUS-1:0] data_q;
   logic [REG_BUS-1:0] load_result;
   logic               mem_op, misaligned;
   logic               issue, complete;
   logic               unused_stall_bits;

   assign mem_op            = is_mem_op(ex_mem_op_i);
   assign misaligned        = mem_op && is_misaligned(ex_mem_op_i, ex_mem_addr_i[1:0]);
   assign unused_stall_bits = ^{stall[STALL_BUS-1:STALL_MEM_BIT+1], stall[STALL_MEM_BIT-1:0]};

   mem_load_align u_load_align (
      .op      (ex_mem_op_i),
      .addr_lo (ex_mem_addr_i[1:0]),
      .rdata   (dbus_rdata_i),
      .result  (load_result)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_next;
   end

   // Next state, stall request and write-back triple.
   always_comb begin
      state_next      = state;
      issue           = 1'b0;
      complete        = 1'b0;
      stallreq_mem_o  = 1'b0;
      addr_err_o      = 1'b0;
      mem_waddr_reg_o = ex_waddr_reg_i;
      mem_we_reg_o    = ex_we_reg_i;
      mem_wdata_o     = ex_wdata_i;
      case (state)
         ST_IDLE: begin
            if (misaligned) begin
               addr_err_o   = 1'b1;
               mem_we_reg_o = 1'b0;
            end else if (mem_op) begin
               stallreq_mem_o = 1'b1;
               issue          = 1'b1;
               state_next     = ST_REQ;
            end
         end
         ST_REQ: begin
            stallreq_mem_o = 1'b1;
            if (dbus_ack_i) begin
               complete   = 1'b1;
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            mem_wdata_o = data_q;
            if (stall[STALL_MEM_BIT] == NO_STOP) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Bus command issue on entry to REQ; result capture on ack.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_q  <= 1'b0;
         cmd_q  <= '0;
         data_q <= '0;
      end else if (issue) begin
         req_q       <= 1'b1;
         cmd_q.we    <= is_store(ex_mem_op_i);
         cmd_q.addr  <= {ex_mem_addr_i[31:2], 2'b00};
         cmd_q.sel   <= lane_sel(ex_mem_op_i, ex_mem_addr_i[1:0]);
         cmd_q.wdata <= store_data(ex_mem_op_i, ex_store_data_i);
      end else if (complete) begin
         req_q  <= 1'b0;
         data_q <= is_store(ex_mem_op_i) ? ex_wdata_i : load_result;
      end
   end

   assign dbus_req_o   = req_q;
   assign dbus_we_o    = cmd_q.we;
   assign dbus_addr_o  = cmd_q.addr;
   assign dbus_sel_o   = cmd_q.sel;
   assign dbus_wdata_o = cmd_q.wdata;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access with a bus responder and a behavioural model.
module tb_mem_access;

   localparam logic [3:0] OP_NONE = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3,
                          OP_LHU = 4'd4, OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  ex_waddr_reg_i;
   logic        ex_we_reg_i;
   logic [31:0] ex_wdata_i;
   logic [3:0]  ex_mem_op_i;
   logic [31:0] ex_mem_addr_i;
   logic [31:0] ex_store_data_i;
   logic [5:0]  stall;
   logic [4:0]  mem_waddr_reg_o;
   logic        mem_we_reg_o;
   logic [31:0] mem_wdata_o;
   logic        stallreq_mem_o;
   logic        addr_err_o;
   logic        dbus_req_o;
   logic        dbus_we_o;
   logic [31:0] dbus_addr_o;
   logic [3:0]  dbus_sel_o;
   logic [31:0] dbus_wdata_o;
   logic [31:0] dbus_rdata_i;
   logic        dbus_ack_i;

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct {
      int          req_cycles;
      int          stall_cycles;
      bit          timed_out;
      logic        bus_we;
      logic [31:0] bus_addr;
      logic [3:0]  bus_sel;
      logic [31:0] bus_wdata;
      logic [31:0] result;
      logic        res_we;
      logic [4:0]  res_waddr;
   } obs_t;

   mem_access dut (
      .clk(clk), .rst(rst),
      .ex_waddr_reg_i(ex_waddr_reg_i), .ex_we_reg_i(ex_we_reg_i), .ex_wdata_i(ex_wdata_i),
      .ex_mem_op_i(ex_mem_op_i), .ex_mem_addr_i(ex_mem_addr_i), .ex_store_data_i(ex_store_data_i),
      .stall(stall),
      .mem_waddr_reg_o(mem_waddr_reg_o), .mem_we_reg_o(mem_we_reg_o), .mem_wdata_o(mem_wdata_o),
      .stallreq_mem_o(stallreq_mem_o), .addr_err_o(addr_err_o),
      .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
      .dbus_sel_o(dbus_sel_o), .dbus_wdata_o(dbus_wdata_o),
      .dbus_rdata_i(dbus_rdata_i), .dbus_ack_i(dbus_ack_i)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   function automatic int m_size(input logic [3:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return 1;
         OP_LH, OP_LHU, OP_SH: return 2;
         default:              return 4;
      endcase
   endfunction

   function automatic bit m_is_store(input logic [3:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic bit m_misaligned(input logic [3:0] op, input logic [31:0] addr);
      return (addr % 32'(m_size(op))) != 32'd0;
   endfunction

   function automatic logic [3:0] m_sel(input logic [3:0] op, input logic [31:0] addr);
      int mask = (1 << m_size(op)) - 1;
      return 4'(mask << (addr % 32'd4));
   endfunction

   function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] addr,
                                          input logic [31:0] rdata);
      int          bits = 8 * m_size(op);
      logic [31:0] v, mask;
      v = rdata >> (8 * (addr % 32'd4));
      if (bits == 32) return v;
      mask = (32'h1 << bits) - 32'h1;
      v = v & mask;
      if (((op == OP_LB) || (op == OP_LH)) && v[bits-1]) v = v | ~mask;
      return v;
   endfunction

   function automatic logic [31:0] m_store(input logic [3:0] op, input logic [31:0] d);
      int          sz = m_size(op);
      logic [31:0] r = '0;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'(d >> (8 * (i % sz)));
      return r;
   endfunction

   // ---------------- stimulus driver / bus responder ----------------
   task automatic drive_none(input logic [31:0] alu);
      ex_mem_op_i = OP_NONE; ex_mem_addr_i = 32'h0; ex_store_data_i = 32'h0;
      ex_wdata_i = alu; ex_waddr_reg_i = 5'd0; ex_we_reg_i = 1'b0;
      stall = 6'd0; dbus_ack_i = 1'b0;
   endtask

   // Presents one memory op, acks after 'delay' wait cycles, returns at the first DONE cycle.
   task automatic run_access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                             input logic [31:0] alu, input logic [4:0] waddr, input logic we,
                             input logic [31:0] rdata, input int delay, input bit stop_in_done,
                             output obs_t o);
      bit done = 0;
      o.req_cycles = 0; o.stall_cycles = 0; o.timed_out = 0;
      o.bus_we = 1'b0; o.bus_addr = '0; o.bus_sel = '0; o.bus_wdata = '0;
      o.result = '0; o.res_we = 1'b0; o.res_waddr = '0;
      @(posedge clk); #1;
      ex_mem_op_i = op; ex_mem_addr_i = addr; ex_store_data_i = sdata;
      ex_wdata_i = alu; ex_waddr_reg_i = waddr; ex_we_reg_i = we;
      stall = 6'd0; dbus_ack_i = 1'b0;
      for (int cyc = 0; cyc < 64 && !done; cyc++) begin
         @(negedge clk);
         dbus_ack_i = 1'b0;
         dbus_rdata_i = $urandom;
         if (stallreq_mem_o) o.stall_cycles++;
         if (dbus_req_o) begin
            if (o.req_cycles == 0) begin
               o.bus_we = dbus_we_o; o.bus_addr = dbus_addr_o;
               o.bus_sel = dbus_sel_o; o.bus_wdata = dbus_wdata_o;
            end
            o.req_cycles++;
            if (o.req_cycles == delay + 1) begin
               dbus_ack_i = 1'b1; dbus_rdata_i = rdata;
            end
         end else if (o.req_cycles > 0 && !stallreq_mem_o) begin
            o.result = mem_wdata_o; o.res_we = mem_we_reg_o; o.res_waddr = mem_waddr_reg_o;
            stall[4] = stop_in_done;
            done = 1;
         end
      end
      o.timed_out = !done;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0;
      drive_none(32'h0000_5A5A);
      ex_waddr_reg_i = 5'd7; ex_we_reg_i = 1'b1; dbus_rdata_i = 32'h0;
      #12;
      tests_run++; if (dbus_req_o !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b expected 0", dbus_req_o); end
      tests_run++; if (dbus_we_o !== 1'b0) begin tests_failed++; $display("FAIL reset_we: got %b expected 0", dbus_we_o); end
      tests_run++; if (dbus_addr_o !== 32'h0) begin tests_failed++; $display("FAIL reset_addr: got %h expected 0", dbus_addr_o); end
      tests_run++; if (dbus_sel_o !== 4'h0) begin tests_failed++; $display("FAIL reset_sel: got %b expected 0", dbus_sel_o); end
      tests_run++; if (dbus_wdata_o !== 32'h0) begin tests_failed++; $display("FAIL reset_wdata: got %h expected 0", dbus_wdata_o); end
      tests_run++; if (stallreq_mem_o !== 1'b0) begin tests_failed++; $display("FAIL reset_stallreq: got %b expected 0", stallreq_mem_o); end
      tests_run++; if (mem_wdata_o !== 32'h0000_5A5A) begin tests_failed++; $display("FAIL reset_passthru: got %h expected 00005a5a", mem_wdata_o); end
      @(negedge clk); rst = 1'b1;
   endtask

   task automatic test_passthrough();
      logic [31:0] w; logic [4:0] a; logic e;
      @(posedge clk); #1;
      drive_none(32'h0000_1234); ex_waddr_reg_i = 5'd3; ex_we_reg_i = 1'b1;
      #1;
      tests_run++; if (mem_wdata_o !== 32'h1234) begin tests_failed++; $display("FAIL alu_wdata: got %h expected 00001234", mem_wdata_o); end
      tests_run++; if (mem_waddr_reg_o !== 5'd3) begin tests_failed++; $display("FAIL alu_waddr: got %0d expected 3", mem_waddr_reg_o); end
      tests_run++; if (mem_we_reg_o !== 1'b1) begin tests_failed++; $display("FAIL alu_we: got %b expected 1", mem_we_reg_o); end
      tests_run++; if (stallreq_mem_o !== 1'b0) begin tests_failed++; $display("FAIL alu_stallreq: got %b expected 0", stallreq_mem_o); end
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         w = $urandom; a = 5'($urandom); e = 1'($urandom);
         ex_mem_op_i = (i % 2 == 0) ? OP_NONE : 4'($urandom_range(9, 15));
         ex_mem_addr_i = $urandom; ex_wdata_i = w; ex_waddr_reg_i = a; ex_we_reg_i = e;
         #1;
         tests_run++; if ({mem_wdata_o, mem_waddr_reg_o, mem_we_reg_o} !== {w, a, e}) begin tests_failed++; $display("FAIL rand_passthru op=%0d: got %h/%0d/%b expected %h/%0d/%b", ex_mem_op_i, mem_wdata_o, mem_waddr_reg_o, mem_we_reg_o, w, a, e); end
         @(negedge clk);
         tests_run++; if ({dbus_req_o, stallreq_mem_o, addr_err_o} !== 3'b000) begin tests_failed++; $display("FAIL rand_nobus op=%0d: got req/stall/err %b%b%b expected 000", ex_mem_op_i, dbus_req_o, stallreq_mem_o, addr_err_o); end
      end
   endtask

   task automatic test_loads_byte();
      obs_t o;
      run_access(OP_LB, 32'h103, 32'h0, 32'h0, 5'd4, 1'b1, 32'h80FF_0000, 0, 1'b0, o);
      tests_run++; if (o.timed_out !== 1'b0) begin tests_failed++; $display("FAIL lb_timeout: got %b expected 0", o.timed_out); end
      tests_run++; if (o.bus_sel !== 4'b1000) begin tests_failed++; $display("FAIL lb_sel: got %b expected 1000", o.bus_sel); end
      tests_run++; if (o.bus_addr !== 32'h100) begin tests_failed++; $display("FAIL lb_addr: got %h expected 00000100", o.bus_addr); end
      tests_run++; if (o.bus_we !== 1'b0) begin tests_failed++; $display("FAIL lb_buswe: got %b expected 0", o.bus_we); end
      tests_run++; if (o.stall_cycles !== 2) begin tests_failed++; $display("FAIL lb_stall: got %0d expected 2", o.stall_cycles); end
      tests_run++; if (o.req_cycles !== 1) begin tests_failed++; $display("FAIL lb_req: got %0d expected 1", o.req_cycles); end
      tests_run++; if (o.result !== 32'hFFFF_FF80) begin tests_failed++; $display("FAIL lb_result: got %h expected ffffff80", o.result); end
      tests_run++; if ({o.res_we, o.res_waddr} !== {1'b1, 5'd4}) begin tests_failed++; $display("FAIL lb_wb: got %b/%0d expected 1/4", o.res_we, o.res_waddr); end
      run_access(OP_LBU, 32'h103, 32'h0, 32'h0, 5'd4, 1'b1, 32'h80FF_0000, 0, 1'b0, o);
      tests_run++; if (o.result !== 32'h0000_0080) begin tests_failed++; $display("FAIL lbu_result: got %h expected 00000080", o.result); end
      tests_run++; if (o.stall_cycles !== 2) begin tests_failed++; $display("FAIL lbu_stall: got %0d expected 2", o.stall_cycles); end
   endtask

   task automatic test_store_half();
      obs_t o;
      run_access(OP_SH, 32'h202, 32'hAAAA_BEEF, 32'h0000_0202, 5'd0, 1'b0, 32'h0, 0, 1'b0, o);
      tests_run++; if (o.bus_we !== 1'b1) begin tests_failed++; $display("FAIL sh_we: got %b expected 1", o.bus_we); end
      tests_run++; if (o.bus_sel !== 4'b1100) begin tests_failed++; $display("FAIL sh_sel: got %b expected 1100", o.bus_sel); end
      tests_run++; if (o.bus_wdata !== 32'hBEEF_BEEF) begin tests_failed++; $display("FAIL sh_wdata: got %h expected beefbeef", o.bus_wdata); end
      tests_run++; if (o.bus_addr !== 32'h200) begin tests_failed++; $display("FAIL sh_addr: got %h expected 00000200", o.bus_addr); end
      tests_run++; if (o.result !== 32'h0000_0202) begin tests_failed++; $display("FAIL sh_result: got %h expected 00000202", o.result); end
   endtask

   task automatic test_wait_states();
      obs_t o;
      run_access(OP_LW, 32'h400, 32'h0, 32'h0, 5'd12, 1'b1, 32'hDEAD_BEEF, 3, 1'b0, o);
      tests_run++; if (o.req_cycles !== 4) begin tests_failed++; $display("FAIL lw_wait_req: got %0d expected 4", o.req_cycles); end
      tests_run++; if (o.stall_cycles !== 5) begin tests_failed++; $display("FAIL lw_wait_stall: got %0d expected 5", o.stall_cycles); end
      tests_run++; if (o.result !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL lw_wait_result: got %h expected deadbeef", o.result); end
   endtask

   task automatic test_misaligned();
      @(posedge clk); #1;
      drive_none(32'h9); ex_mem_op_i = OP_LW; ex_mem_addr_i = 32'h2; ex_we_reg_i = 1'b1; ex_waddr_reg_i = 5'd6;
      #1;
      tests_run++; if (addr_err_o !== 1'b1) begin tests_failed++; $display("FAIL mis_err: got %b expected 1", addr_err_o); end
      tests_run++; if (mem_we_reg_o !== 1'b0) begin tests_failed++; $display("FAIL mis_we: got %b expected 0", mem_we_reg_o); end
      tests_run++; if (stallreq_mem_o !== 1'b0) begin tests_failed++; $display("FAIL mis_stallreq: got %b expected 0", stallreq_mem_o); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests_run++; if (dbus_req_o !== 1'b0) begin tests_failed++; $display("FAIL mis_noreq cyc%0d: got %b expected 0", i, dbus_req_o); end
      end
   endtask

   task automatic test_reset_in_req();
      obs_t o;
      @(posedge clk); #1;
      drive_none(32'h11); ex_mem_op_i = OP_LW; ex_mem_addr_i = 32'h40; ex_waddr_reg_i = 5'd9; ex_we_reg_i = 1'b1;
      @(negedge clk);
      @(negedge clk);
      tests_run++; if (dbus_req_o !== 1'b1) begin tests_failed++; $display("FAIL rreq_req: got %b expected 1", dbus_req_o); end
      #1 rst = 1'b0; ex_mem_op_i = OP_NONE;
      #1;
      tests_run++; if ({dbus_req_o, dbus_sel_o, dbus_addr_o} !== 37'h0) begin tests_failed++; $display("FAIL rreq_async: got req %b sel %b addr %h expected all 0", dbus_req_o, dbus_sel_o, dbus_addr_o); end
      @(posedge clk); #2 rst = 1'b1;
      @(negedge clk); dbus_ack_i = 1'b1; dbus_rdata_i = 32'hCAFE_F00D;
      @(negedge clk); dbus_ack_i = 1'b0;
      tests_run++; if ({dbus_req_o, stallreq_mem_o} !== 2'b00) begin tests_failed++; $display("FAIL rreq_ackign: got req/stall %b%b expected 00", dbus_req_o, stallreq_mem_o); end
      tests_run++; if (mem_wdata_o !== 32'h11) begin tests_failed++; $display("FAIL rreq_data: got %h expected 00000011", mem_wdata_o); end
      run_access(OP_LW, 32'h80, 32'h0, 32'h0, 5'd9, 1'b1, 32'h0BAD_F00D, 1, 1'b0, o);
      tests_run++; if (o.result !== 32'h0BAD_F00D) begin tests_failed++; $display("FAIL rreq_next_result: got %h expected 0badf00d", o.result); end
      tests_run++; if (o.req_cycles !== 2) begin tests_failed++; $display("FAIL rreq_next_req: got %0d expected 2", o.req_cycles); end
   endtask

   task automatic test_done_hold();
      obs_t o;
      run_access(OP_LH, 32'h306, 32'h0, 32'h0, 5'd2, 1'b1, 32'h8001_0000, 0, 1'b1, o);
      tests_run++; if (o.result !== 32'hFFFF_8001) begin tests_failed++; $display("FAIL hold_result: got %h expected ffff8001", o.result); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         dbus_ack_i = (i == 1); dbus_rdata_i = 32'h1234_5678;
         tests_run++; if ({mem_wdata_o, dbus_req_o, stallreq_mem_o} !== {32'hFFFF_8001, 2'b00}) begin tests_failed++; $display("FAIL hold_stable cyc%0d: got %h req %b stall %b expected ffff8001 0 0", i, mem_wdata_o, dbus_req_o, stallreq_mem_o); end
         if (i == 2) begin stall = 6'd0; dbus_ack_i = 1'b0; end
      end
      @(posedge clk); #1;
      drive_none(32'h77);
      #1;
      tests_run++; if (mem_wdata_o !== 32'h77) begin tests_failed++; $display("FAIL hold_release: got %h expected 00000077", mem_wdata_o); end
      @(negedge clk);
      tests_run++; if (dbus_req_o !== 1'b0) begin tests_failed++; $display("FAIL hold_noreq: got %b expected 0", dbus_req_o); end
   endtask

   task automatic test_random();
      obs_t        o;
      logic [3:0]  op;
      logic [31:0] addr, sdata, alu, rdata, exp;
      logic [4:0]  wa;
      logic        we;
      int          dly;
      for (int n = 0; n < 40; n++) begin
         op = 4'($urandom_range(1, 8));
         addr = $urandom;
         if ($urandom_range(0, 2) != 0) addr = addr & ~(32'(m_size(op)) - 32'd1);
         sdata = $urandom; alu = $urandom; rdata = $urandom;
         wa = 5'($urandom); we = 1'($urandom); dly = $urandom_range(0, 3);
         if (m_misaligned(op, addr)) begin
            @(posedge clk); #1;
            drive_none(alu); ex_mem_op_i = op; ex_mem_addr_i = addr; ex_we_reg_i = we;
            @(negedge clk);
            tests_run++; if ({addr_err_o, stallreq_mem_o, mem_we_reg_o, dbus_req_o} !== 4'b1000) begin tests_failed++; $display("FAIL rnd_mis op=%0d addr=%h: got err/stall/we/req %b%b%b%b expected 1000", op, addr, addr_err_o, stallreq_mem_o, mem_we_reg_o, dbus_req_o); end
         end else begin
            run_access(op, addr, sdata, alu, wa, we, rdata, dly, 1'b0, o);
            exp = m_is_store(op) ? alu : m_load(op, addr, rdata);
            tests_run++; if (o.timed_out !== 1'b0) begin tests_failed++; $display("FAIL rnd_timeout op=%0d: got %b expected 0", op, o.timed_out); end
            tests_run++; if ({o.bus_addr, o.bus_sel, o.bus_we} !== {addr & ~32'h3, m_sel(op, addr), 1'(m_is_store(op))}) begin tests_failed++; $display("FAIL rnd_bus op=%0d addr=%h: got %h/%b/%b expected %h/%b/%b", op, addr, o.bus_addr, o.bus_sel, o.bus_we, addr & ~32'h3, m_sel(op, addr), m_is_store(op)); end
            if (m_is_store(op)) begin
               tests_run++; if (o.bus_wdata !== m_store(op, sdata)) begin tests_failed++; $display("FAIL rnd_wdata op=%0d: got %h expected %h", op, o.bus_wdata, m_store(op, sdata)); end
            end
            tests_run++; if (o.result !== exp) begin tests_failed++; $display("FAIL rnd_result op=%0d addr=%h: got %h expected %h", op, addr, o.result, exp); end
            tests_run++; if ({o.req_cycles, o.stall_cycles} !== {dly + 1, dly + 2}) begin tests_failed++; $display("FAIL rnd_timing op=%0d dly=%0d: got req %0d stall %0d expected %0d %0d", op, dly, o.req_cycles, o.stall_cycles, dly + 1, dly + 2); end
            tests_run++; if ({o.res_we, o.res_waddr} !== {we, wa}) begin tests_failed++; $display("FAIL rnd_wb op=%0d: got %b/%0d expected %b/%0d", op, o.res_we, o.res_waddr, we, wa); end
         end
      end
      @(posedge clk); #1;
      drive_none(32'h0);
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_loads_byte();
      test_store_half();
      test_wait_states();
      test_misaligned();
      test_reset_in_req();
      test_done_hold();
      test_random();
      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the five-stage integer pipeline, between the EX/MEM and MEM/WB pipeline registers. Passes ALU results through unchanged. Executes loads and stores over a single-outstanding request/acknowledge data bus, stalling the pipeline through the stall controller until the access completes. Presents the write-back triple (register address, write enable, data) to the MEM/WB register.

## Interface
Parameters:
- none; widths come from `defines.v` (`RegBus` = 32, `RegAddrBus` = 5, `StallBus` = 6, `MemOpBus` = 4).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  one clock; reset is asynchronous and active-low; rst = 0 forces reset state immediately.
- ex_waddr_reg_i  in  `RegAddrBus`  destination register from EX/MEM.
- ex_we_reg_i  in  1  register write enable from EX/MEM.
- ex_wdata_i  in  `RegBus`  ALU result.
- ex_mem_op_i  in  `MemOpBus`  memory operation code.
- ex_mem_addr_i  in  `RegBus`  effective address.
- ex_store_data_i  in  `RegBus`  store source register value.
- stall  in  `StallBus`  pipeline stall vector; bit 4 = MEM stage held.
- mem_waddr_reg_o  out  `RegAddrBus`  to MEM/WB.
- mem_we_reg_o  out  1  to MEM/WB.
- mem_wdata_o  out  `RegBus`  to MEM/WB.
- stallreq_mem_o  out  1  stall request to the stall controller.
- addr_err_o  out  1  misaligned access flag.
- dbus_req_o  out  1  bus request, registered.
- dbus_we_o  out  1  1 = write, registered.
- dbus_addr_o  out  32  word-aligned address ({addr[31:2],2'b00}), registered.
- dbus_sel_o  out  4  byte-lane enables, registered.
- dbus_wdata_o  out  32  store data, lane-replicated, registered.
- dbus_rdata_i  in  32  read data, valid with ack.
- dbus_ack_i  in  1  one-cycle completion strobe.

## Operation
- Op codes: 0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW. Codes 9–15 are treated as NONE.
- Non-memory op (NONE):
  - Outputs combinationally equal the ex_* inputs.
  - stallreq_mem_o = 0; no bus activity.
- Alignment:
  - Halfword ops require addr[0] = 0; word ops require addr[1:0] = 0.
  - A misaligned op drives addr_err_o = 1 combinationally, issues no bus access, forces mem_we_reg_o = 0 and stallreq_mem_o = 0, and stays in IDLE.
- Byte lanes are little-endian:
  - Byte at addr[1:0] = k uses sel bit k and data bits 8k+7:8k.
  - Halfword at addr[1] = h uses sel 2'b11 << 2h.
  - Word uses sel 4'b1111.
- Store data: SB drives {4{d[7:0]}}, SH drives {2{d[15:0]}}, SW drives d.
- Load result: LB/LH sign-extend, LBU/LHU zero-extend.
- FSM states IDLE, REQ, DONE:
  - IDLE, aligned memory op present: stallreq_mem_o = 1 (combinational). At the clock edge, register bus address/sel/we/wdata, set dbus_req_o = 1, go to REQ.
  - REQ: stallreq_mem_o = 1 and bus outputs held. On dbus_ack_i, clear dbus_req_o, latch the extended load data (stores latch ex_wdata_i), go to DONE.
  - DONE: stallreq_mem_o = 0. Outputs come from the latched data, with waddr/we from the inputs (EX/MEM is held). If stall[4] = NoStop, go to IDLE; otherwise stay in DONE.
- Acks received in IDLE or DONE are ignored.
- Reset: state = IDLE, dbus_req_o = 0, dbus_we_o = 0, dbus_addr_o = 0, dbus_sel_o = 0, dbus_wdata_o = 0, latched data = 0. Combinational outputs follow the inputs in IDLE.
- Reset during REQ abandons the access; a later ack is ignored.

## Timing
- Pass-through ops add zero latency (combinational).
- Zero-wait-state access:
  - Op presented in cycle 0.
  - dbus_req_o high in cycle 1; ack sampled in cycle 1.
  - DONE in cycle 2; MEM/WB captures at the end of cycle 2.
  - Total: 2 stall cycles.
- Each wait cycle of the bus adds one stall cycle.
- dbus_req_o is held high until the ack edge and dropped the following cycle. Back-to-back memory ops therefore always have at least one req-low cycle between them.
- Only one access is outstanding at a time.

## Structure
- Op codes, `MemOpBus`, `StallBus`, and `Stop`/`NoStop` live in the shared `defines.v`.
- Sub-module `mem_load_align`: purely combinational; takes (op, addr[1:0], rdata) and produces the extended 32-bit result. It is reused later by a future cache.

## Test plan
- ALU op: NONE, waddr = 3, we = 1, wdata = 0x1234 -> outputs identical in the same cycle; stallreq_mem_o = 0; dbus_req_o stays 0.
- LB at addr 0x103, zero-wait ack, rdata = 0x80FF_0000 -> sel = 4'b1000, addr = 0x100, stall for 2 cycles, mem_wdata_o = 0xFFFF_FF80. Repeat with LBU -> 0x0000_0080.
- SH at 0x202, store data 0xAAAA_BEEF -> dbus_we_o = 1, sel = 4'b1100, wdata = 0xBEEF_BEEF.
- LW with ack delayed 3 cycles, rdata = 0xDEADBEEF -> req high for 4 cycles, stallreq_mem_o high for 5 cycles, result = 0xDEADBEEF.
- LW at 0x2 -> addr_err_o = 1, no request issued, mem_we_reg_o = 0.
- Reset pulsed while in REQ, then an ack arrives -> state IDLE, dbus_req_o = 0, ack ignored; next instruction processed normally. Separately: DONE held with stall[4] = Stop for 3 cycles -> outputs stable, no re-request issued.
